fetch_queue_pcu: RTL and testbench
==================================

// Module: fetch_queue_pcu
// PURPOSE
//   Parametrised fetch stage: owns the fetch PC and drives the I-cache request bus.
//   Buffers fetched instructions, each with its own PC, in a DEPTH-entry FIFO, so
//   decode stalls and I-cache misses are decoupled.
//   Sits between branch predictor / hazard unit and the IF/ID boundary.
//   Adds over the single-register fetch: queueing, per-entry PC, and a valid/ready
//   handshake to decode.
// PARAMETERS
//   ADDR_W      32  fetch address width
//   INSTR_W     32  instruction width
//   DEPTH       4   fetch queue entries; power of 2, >= 2
//   INSTR_BYTES 4   sequential PC increment
//   RESET_PC    0   fetch PC after reset
// PORTS
//   Clk            in  1          clock, rising edge
//   Rst_n          in  1          reset, asynchronous, active-low
//   Flush          in  1          redirect: empty queue, fetch from FlushAddr
//   FlushAddr      in  ADDR_W     redirect target
//   PCStall        in  1          hold fetch PC, no new fetch
//   PredTaken      in  1          predictor: current fetch is a taken branch
//   PredTarget     in  ADDR_W     predicted target
//   Icache_bus_out out ADDR_W     I-cache request address (= FetchPC)
//   Icache_bus_in  in  INSTR_W+1  {miss, data}; combinational response to request
//   IR             out INSTR_W    head instruction
//   IR_PC          out ADDR_W     PC of head instruction
//   IR_Valid       out 1          queue non-empty
//   ID_Ready       in  1          decode accepts head this cycle
//   Count          out $clog2(DEPTH+1)  occupied entries
//   Imiss          out 1          miss = Icache_bus_in[INSTR_W] && !PCStall && !Flush
// BEHAVIOUR
//   Reset (async, Rst_n=0): FetchPC=RESET_PC; pointers and Count = 0.
//     IR_Valid=0; IR and IR_PC read as 0 while empty. Takes effect mid-cycle,
//     with no clock edge needed.
//   pop  = IR_Valid && ID_Ready && !Flush
//   full = (Count == DEPTH)
//   push = !Flush && !PCStall && !miss && (!full || pop)
//   Push: write {FetchPC, data} at wr_ptr; wr_ptr++ (wraps mod DEPTH).
//     FetchPC <= PredTaken ? PredTarget : FetchPC + INSTR_BYTES
//     (ADDR_W modulo wrap). PredTaken/PredTarget are ignored when there is no push.
//   No push and no Flush: FetchPC holds.
//   Pop: rd_ptr++ (wraps).
//   Count: +1 on push only, -1 on pop only, unchanged on both/neither.
//   Full: push only when a pop occurs the same cycle (both happen, Count stays DEPTH).
//   Empty: pop is impossible; IR/IR_PC are don't-care, forced to 0.
//   Latency: instruction fetched at edge N is visible on IR after edge N; min 1 cycle.
//   Flush (highest priority over stall, miss, pred, pop):
//     next edge sets Count=0, rd_ptr=wr_ptr=0, FetchPC=FlushAddr.
//     Icache_bus_out=FlushAddr in the following cycle. Head is not consumed.
//   Priority: Rst_n > Flush > PCStall > miss > full.
//   Storage array needs no reset; only pointers, Count and FetchPC are reset.
// TESTING
//   T1 reset release, no miss, ID_Ready=1: Icache_bus_out 0,4,8,...;
//      IR_PC 0,4,8 one cycle behind; Count stays 1.
//   T2 ID_Ready=0, DEPTH=4: Count 1..4, Icache_bus_out holds 0x10 once full.
//      Then ID_Ready=1: push+pop, Count stays 4, IR_PC advances 0x0->0x4.
//   T3 miss at 0x8 for 3 cycles: Imiss=1, FetchPC holds 0x8, no push,
//      queue drains; 4th cycle hit pushes 0x8.
//   T4 PredTaken=1, PredTarget=0x100 at FetchPC 0x4: next request 0x100;
//      queue holds PCs 0x4 then 0x100.
//   T5 Count=3, Flush=1, FlushAddr=0x200, PredTaken=1, PCStall=1:
//      next cycle Count=0, IR_Valid=0, Icache_bus_out=0x200.
//   T6 Rst_n low between edges with Count=2: Count=0, IR_Valid=0 and
//      Icache_bus_out=RESET_PC immediately, no edge.

Source files
------------

// File: rtl/fetch_queue_pcu.sv
// fetch_queue_pcu
//   Fetch stage with a DEPTH-entry instruction queue. Owns the fetch PC,
//   drives the I-cache request address and buffers each fetched instruction
//   with its own PC. Decode drains the queue through a valid/ready handshake.
//   This decouples decode stalls and I-cache misses from fetch.
// Ports
//   Clk, Rst_n       clock (rising edge); reset (asynchronous, active-low)
//   Flush, FlushAddr redirect: empty the queue and fetch from FlushAddr
//   PCStall          hold the fetch PC and fetch nothing new
//   PredTaken/Target predictor redirect applied to a pushed fetch
//   Icache_bus_out   request address (the fetch PC)
//   Icache_bus_in    {miss, data}, combinational response to the request
//   IR, IR_PC        head instruction and its PC (0 while empty)
//   IR_Valid         queue non-empty
//   ID_Ready         decode accepts the head this cycle
//   Count            occupied entries
//   Imiss            miss seen by an otherwise live fetch
module fetch_queue_pcu #(
  parameter int ADDR_W      = 32,
  parameter int INSTR_W     = 32,
  parameter int DEPTH       = 4,
  parameter int INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Flush,
  input  logic [ADDR_W-1:0]  FlushAddr,
  input  logic               PCStall,
  input  logic               PredTaken,
  input  logic [ADDR_W-1:0]  PredTarget,
  output logic [ADDR_W-1:0]  Icache_bus_out,
  input  logic [INSTR_W:0]   Icache_bus_in,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  IR_PC,
  output logic               IR_Valid,
  input  logic               ID_Ready,
  output logic [CNT_W-1:0]   Count,
  output logic               Imiss
);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               miss;
  logic [INSTR_W-1:0] fetch_data;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic [ADDR_W-1:0]  next_pc;

  assign miss       = Icache_bus_in[INSTR_W];
  assign fetch_data = Icache_bus_in[INSTR_W-1:0];

  // Handshake and push/pop qualification; Flush overrides everything.
  always_comb begin
    empty   = (count == CNT_W'(0));
    full    = (count == CNT_W'(DEPTH));
    pop     = !empty && ID_Ready && !Flush;
    // A full queue can still accept a fetch when the head leaves this cycle.
    push    = !Flush && !PCStall && !miss && (!full || pop);
    next_pc = fetch_pc + ADDR_W'(INSTR_BYTES);
    if (PredTaken) begin
      next_pc = PredTarget;
    end else begin
      next_pc = fetch_pc + ADDR_W'(INSTR_BYTES);
    end
  end

  // Fetch PC, pointers and occupancy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= PTR_W'(0);
      rd_ptr   <= PTR_W'(0);
      count    <= CNT_W'(0);
    end else if (Flush) begin
      fetch_pc <= FlushAddr;
      wr_ptr   <= PTR_W'(0);
      rd_ptr   <= PTR_W'(0);
      count    <= CNT_W'(0);
    end else begin
      if (push) begin
        fetch_pc <= next_pc;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= fetch_data;
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    IR    = '0;
    IR_PC = '0;
    if (!empty) begin
      IR    = instr_mem[rd_ptr];
      IR_PC = pc_mem[rd_ptr];
    end else begin
      IR    = '0;
      IR_PC = '0;
    end
  end

  assign Icache_bus_out = fetch_pc;
  assign IR_Valid       = !empty;
  assign Count          = count;
  assign Imiss          = miss && !PCStall && !Flush;

endmodule

// File: tb/tb_fetch_queue_pcu.sv
module tb_fetch_queue_pcu;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               Clk = 1'b0;
  logic               Rst_n;
  logic               Flush;
  logic [ADDR_W-1:0]  FlushAddr;
  logic               PCStall;
  logic               PredTaken;
  logic [ADDR_W-1:0]  PredTarget;
  logic [ADDR_W-1:0]  Icache_bus_out;
  logic [INSTR_W:0]   Icache_bus_in;
  logic [INSTR_W-1:0] IR;
  logic [ADDR_W-1:0]  IR_PC;
  logic               IR_Valid;
  logic               ID_Ready;
  logic [CNT_W-1:0]   Count;
  logic               Imiss;
  logic               miss_in;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  ent_t              q[$];
  logic [ADDR_W-1:0] m_pc;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign Icache_bus_in = {miss_in, instr_of(Icache_bus_out)};

  always #5 Clk = ~Clk;

  fetch_queue_pcu #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                    .INSTR_BYTES(4), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .FlushAddr(FlushAddr),
    .PCStall(PCStall), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .Icache_bus_out(Icache_bus_out), .Icache_bus_in(Icache_bus_in),
    .IR(IR), .IR_PC(IR_PC), .IR_Valid(IR_Valid), .ID_Ready(ID_Ready),
    .Count(Count), .Imiss(Imiss)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] e_ir;
    logic [63:0] e_pc;
    e_ir = 64'd0;
    e_pc = 64'd0;
    if (q.size() != 0) begin
      e_ir = 64'(q[0].ins);
      e_pc = 64'(q[0].pc);
    end
    chk({tag, "_bus"},   64'(Icache_bus_out), 64'(m_pc));
    chk({tag, "_count"}, 64'(Count), 64'(q.size()));
    chk({tag, "_valid"}, 64'(IR_Valid), 64'(q.size() != 0));
    chk({tag, "_ir"},    64'(IR), e_ir);
    chk({tag, "_irpc"},  64'(IR_PC), e_pc);
    chk({tag, "_imiss"}, 64'(Imiss), 64'(miss_in && !PCStall && !Flush));
  endtask

  // One clock: check current outputs, advance the model, take the edge.
  task automatic cycle(input string tag);
    bit pop;
    bit push;
    #1;
    check_outputs(tag);
    pop  = (q.size() != 0) && ID_Ready && !Flush;
    push = !Flush && !PCStall && !miss_in && ((q.size() < DEPTH) || pop);
    if (Flush) begin
      q.delete();
      m_pc = FlushAddr;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, ins: instr_of(m_pc)});
        m_pc = PredTaken ? PredTarget : m_pc + 32'd4;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Flush = 1'b0; FlushAddr = 32'h0; PCStall = 1'b0;
    PredTaken = 1'b0; PredTarget = 32'h0; miss_in = 1'b0;
  endtask

  task automatic flush_to(input logic [ADDR_W-1:0] a);
    Flush = 1'b1; FlushAddr = a;
    cycle("flush");
    Flush = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    ID_Ready = 1'b1;
    idle_inputs();
    q.delete();
    m_pc = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset");
    Rst_n = 1'b1;

    // T1: streaming with decode always ready
    for (int i = 0; i < 4; i++) cycle("t1");
    chk("t1_irpc_c", 64'(IR_PC), 64'h0C);
    chk("t1_count1", 64'(Count), 64'd1);

    // T2: fill to DEPTH, then push and pop together while full
    ID_Ready = 1'b0;
    flush_to(32'h0);
    for (int i = 0; i < 5; i++) cycle("t2");
    chk("t2_full_count", 64'(Count), 64'd4);
    chk("t2_full_bus", 64'(Icache_bus_out), 64'h10);
    ID_Ready = 1'b1;
    cycle("t2b");
    chk("t2_both_count", 64'(Count), 64'd4);
    chk("t2_both_irpc", 64'(IR_PC), 64'h4);

    // T3: three-cycle miss at 0x8 while the queue drains
    flush_to(32'h0);
    cycle("t3"); cycle("t3");
    miss_in = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t3m");
    chk("t3_hold_pc", 64'(Icache_bus_out), 64'h8);
    chk("t3_drained", 64'(Count), 64'd0);
    miss_in = 1'b0;
    cycle("t3h");
    chk("t3_push8", 64'(IR_PC), 64'h8);

    // T4: predicted-taken redirect at 0x4
    ID_Ready = 1'b0;
    flush_to(32'h0);
    cycle("t4");
    PredTaken = 1'b1; PredTarget = 32'h100;
    cycle("t4p");
    PredTaken = 1'b0;
    chk("t4_target", 64'(Icache_bus_out), 64'h100);
    cycle("t4");
    chk("t4_q2", 64'(q.size() == 3 ? q[2].pc : 32'hDEAD), 64'h100);

    // T5: flush dominates stall and prediction
    flush_to(32'h0);
    for (int i = 0; i < 3; i++) cycle("t5");
    chk("t5_count3", 64'(Count), 64'd3);
    Flush = 1'b1; FlushAddr = 32'h200; PredTaken = 1'b1; PCStall = 1'b1;
    cycle("t5f");
    idle_inputs();
    chk("t5_count0", 64'(Count), 64'd0);
    chk("t5_bus", 64'(Icache_bus_out), 64'h200);

    // T6: asynchronous reset between edges
    cycle("t6"); cycle("t6");
    chk("t6_count2", 64'(Count), 64'd2);
    Rst_n = 1'b0;
    #1;
    q.delete();
    m_pc = 32'h0;
    chk("t6_count", 64'(Count), 64'd0);
    chk("t6_valid", 64'(IR_Valid), 64'd0);
    chk("t6_bus", 64'(Icache_bus_out), 64'h0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      Flush      = ($urandom_range(15) == 0);
      FlushAddr  = {$urandom_range(1023), 2'b00};
      PCStall    = ($urandom_range(3) == 0);
      miss_in    = ($urandom_range(3) == 0);
      PredTaken  = ($urandom_range(3) == 0);
      PredTarget = {$urandom(), 2'b00} >> 2;
      PredTarget = {PredTarget[ADDR_W-3:0], 2'b00};
      ID_Ready   = ($urandom_range(1) == 1);
      cycle("rnd");
    end
    idle_inputs();
    #1;
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
